// File: rtl/nn_pkg.sv
// Shared constants and types for the int8 input MAC.
// Lane geometry, default depth and controller state encoding.
package nn_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int LANES     = 4;
    localparam int LANE_W    = 8;
    localparam int PROD_W    = 2 * LANE_W;
    localparam int ACC_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/nn_dot4.sv
// Four-lane signed int8 dot product: registered products, then
// a sign-extended sum folded into a 32-bit accumulator.
import nn_pkg::*;

module nn_dot4 (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_v,
    input  logic [31:0]      act,
    input  logic [31:0]      wgt,
    output logic [ACC_W-1:0] acc
);

    logic signed [PROD_W-1:0] prod_q [LANES];
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [PROD_W-1:0] ax, wx;
    logic                     p_v_q, p_v_d;
    logic [ACC_W-1:0]         acc_q, acc_d, sum;

    always_comb begin
        p_v_d = in_v;
        ax    = '0;
        wx    = '0;
        sum   = '0;
        for (int i = 0; i < LANES; i++) begin
            ax = $signed({{LANE_W{act[i*LANE_W+LANE_W-1]}},
                          act[i*LANE_W +: LANE_W]});
            wx = $signed({{LANE_W{wgt[i*LANE_W+LANE_W-1]}},
                          wgt[i*LANE_W +: LANE_W]});
            // |a*b| <= 16384, so the low half of the product is exact
            prod_d[i] = ax * wx;
        end
        for (int i = 0; i < LANES; i++) begin
            sum = sum + {{(ACC_W-PROD_W){prod_q[i][PROD_W-1]}},
                         prod_q[i]};
        end
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (p_v_q) begin
            acc_d = acc_q + sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_v_q <= 1'b0;
            acc_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            p_v_q <= p_v_d;
            acc_q <= acc_d;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/nn_input_mac.sv
// Streams up to DEPTH packed int8 words from a FIFO, multiplies them
// against a local weight memory and reports the (optionally ReLU'd) sum.
import nn_pkg::*;

module nn_input_mac #(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  len,
    input  logic        relu_en,
    input  logic        wgt_we,
    input  logic [2:0]  wgt_addr,
    input  logic [31:0] wgt_data,
    output logic        fifo_ce,
    input  logic [31:0] fifo_data_i,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result
);

    localparam int         IW      = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_N = 4'(DEPTH);

    logic [31:0] wgt_q [DEPTH];

    state_t      state_q, state_d;
    logic [3:0]  n_q, n_d, cnt_q, cnt_d, n_eff;
    logic        relu_q, relu_d;
    logic        fifo_ce_q, fifo_ce_d;
    logic        busy_q, busy_d;
    logic        rv_q, rv_d;
    logic [31:0] result_q, result_d;
    logic        clr;

    logic        s1_v_q, s1_v_d;
    logic [31:0] s1_act_q, s1_act_d;
    logic [31:0] s1_wgt_q, s1_wgt_d;
    logic [31:0] acc;

    assign n_eff = (len > DEPTH_N) ? DEPTH_N : len;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        relu_d    = relu_q;
        fifo_ce_d = fifo_ce_q;
        busy_d    = busy_q;
        rv_d      = 1'b0;
        result_d  = result_q;
        clr       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    clr    = 1'b1;
                    n_d    = n_eff;
                    relu_d = relu_en;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (n_eff == '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d   = RUN;
                        fifo_ce_d = 1'b1;
                    end
                end else if (rv_q) begin
                    busy_d = 1'b0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q + 4'd1 == n_q) begin
                    state_d   = DRAIN;
                    fifo_ce_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            DRAIN: begin
                // lets the last word clear the product and sum stages
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d  = IDLE;
                rv_d     = 1'b1;
                result_d = (relu_q && acc[31]) ? '0 : acc;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s1_v_d   = fifo_ce_q;
        s1_act_d = s1_act_q;
        s1_wgt_d = s1_wgt_q;
        if (fifo_ce_q) begin
            s1_act_d = fifo_data_i;
            s1_wgt_d = wgt_q[cnt_q[IW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            cnt_q     <= '0;
            relu_q    <= 1'b0;
            fifo_ce_q <= 1'b0;
            busy_q    <= 1'b0;
            rv_q      <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            relu_q    <= relu_d;
            fifo_ce_q <= fifo_ce_d;
            busy_q    <= busy_d;
            rv_q      <= rv_d;
            result_q  <= result_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_act_q <= '0;
            s1_wgt_q <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_act_q <= s1_act_d;
            s1_wgt_q <= s1_wgt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                wgt_q[i] <= '0;
            end
        end else if (wgt_we && !busy_q) begin
            wgt_q[wgt_addr] <= wgt_data;
        end
    end

    nn_dot4 u_dot4 (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .in_v (s1_v_q),
        .act  (s1_act_q),
        .wgt  (s1_wgt_q),
        .acc  (acc)
    );

    assign fifo_ce      = fifo_ce_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign result       = result_q;

endmodule

// File: tb/tb_nn_input_mac.sv
// Scoreboard bench for nn_input_mac: runs push expected result,
// latency and pop count; a negedge monitor checks each completion.
module tb_nn_input_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  len_i = '0;
    logic        relu_en = 1'b0;
    logic        wgt_we = 1'b0;
    logic [2:0]  wgt_addr = '0;
    logic [31:0] wgt_data = '0;
    logic        fifo_ce;
    logic [31:0] fifo_data_i;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          pops;
    } exp_t;

    exp_t        exp_q[$];
    int          vec = 0;
    int          miss = 0;
    int          cyc = 0;
    int          pops = 0;
    int          base = 0;
    int          start_cyc = 0;
    int          start_pops = 0;
    logic [31:0] fbuf [16];

    nn_input_mac #(.DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len_i),
        .relu_en      (relu_en),
        .wgt_we       (wgt_we),
        .wgt_addr     (wgt_addr),
        .wgt_data     (wgt_data),
        .fifo_ce      (fifo_ce),
        .fifo_data_i  (fifo_data_i),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: head word tracks the number of pops seen.
    assign fifo_data_i = fbuf[4'(pops - base)];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_ce) pops <= pops + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected result_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
                    chk("pops", 32'(pops - start_pops), 32'(e.pops));
                end
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wgt_we = 1'b1;
        wgt_addr = a;
        wgt_data = d;
        @(negedge clk);
        wgt_we = 1'b0;
    endtask

    task automatic wr_all(input logic [31:0] d);
        for (int i = 0; i < 8; i++) wr(3'(i), d);
    endtask

    task automatic load(input logic [31:0] w, input int inc);
        base = pops;
        for (int i = 0; i < 16; i++)
            fbuf[i] = (inc != 0) ? w * 32'(i + 1) : w;
    endtask

    // mode 0: plain, 1: weight 0 written with start, 2: disturb mid-run
    task automatic run(input logic [3:0] l, input logic r,
                       input logic [31:0] er, input int ep,
                       input int mode, input logic [31:0] wd);
        exp_t e;
        bit   done;
        @(negedge clk);
        start = 1'b1;
        len_i = l;
        relu_en = r;
        if (mode == 1) begin
            wgt_we = 1'b1;
            wgt_addr = 3'd0;
            wgt_data = wd;
        end
        e.res = er;
        e.lat = ep + 3;
        e.pops = ep;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wgt_we = 1'b0;
        start_cyc = cyc;
        start_pops = pops;
        chk("busy after start", 32'(busy), 32'd1);
        chk("fifo_ce after start", 32'(fifo_ce), 32'(ep != 0));
        if (mode == 2) begin
            @(negedge clk);
            start = 1'b1;
            len_i = 4'd1;
            wgt_we = 1'b1;
            wgt_addr = 3'd1;
            wgt_data = 32'h7f7f7f7f;
            @(negedge clk);
            start = 1'b0;
            wgt_we = 1'b0;
        end
        done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("run completes", 32'(done), 32'd1);
    endtask

    initial begin
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset fifo_ce", 32'(fifo_ce), 32'd0);
        chk("reset result_valid", 32'(result_valid), 32'd0);
        chk("reset result", result, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        wr_all(32'h01010101);
        load(32'h02020202, 0);
        run(4'd3, 1'b0, 32'd24, 3, 0, 0);

        wr(3'd0, 32'h000000ff);
        load(32'h00000005, 0);
        run(4'd1, 1'b0, 32'hfffffffb, 1, 0, 0);
        load(32'h00000005, 0);
        run(4'd1, 1'b1, 32'd0, 1, 0, 0);

        run(4'd0, 1'b0, 32'd0, 0, 0, 0);

        wr(3'd0, 32'h01010101);
        load(32'h01010101, 1);
        run(4'd12, 1'b0, 32'd144, 8, 0, 0);

        load(32'h01010101, 0);
        run(4'd1, 1'b0, 32'd12, 1, 1, 32'h03030303);

        load(32'h01010101, 0);
        run(4'd2, 1'b0, 32'd16, 2, 2, 0);
        load(32'h01010101, 0);
        run(4'd2, 1'b0, 32'd16, 2, 0, 0);

        wr(3'd0, 32'h80808080);
        load(32'h80808080, 0);
        run(4'd1, 1'b1, 32'h00010000, 1, 0, 0);

        load(32'h01010101, 0);
        @(negedge clk);
        start = 1'b1;
        len_i = 4'd4;
        relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid-run fifo_ce", 32'(fifo_ce), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst fifo_ce", 32'(fifo_ce), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        load(32'h01010101, 0);
        run(4'd1, 1'b0, 32'd0, 1, 0, 0);
        wr_all(32'h01010101);
        load(32'h02020202, 0);
        run(4'd3, 1'b0, 32'd24, 3, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/nn_input_mac.md
NN_INPUT_MAC -- requirements
Module: nn_input_mac

Interface
REQ-001 SHALL have parameter DEPTH, default 8, max words per run and weight-memory depth (equals input FIFO depth).
REQ-002 SHALL have exactly one clock and one reset: reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  run request, sampled on a clk edge while idle.
REQ-006 len  input  4  words to consume; sampled with start.
REQ-007 relu_en  input  1  apply ReLU to the result; sampled with start.
REQ-008 wgt_we  input  1  weight write strobe.
REQ-009 wgt_addr  input  3  weight word index.
REQ-010 wgt_data  input  32  four packed signed int8 weights, lane0 = bits [7:0].
REQ-011 fifo_ce  output  1  FIFO read enable; the FIFO pops on a clk edge with ce=1 and we=0.
REQ-012 fifo_data_i  input  32  FIFO head word, four packed signed int8 activations, valid while fifo_ce=1.
REQ-013 busy  output  1  high from the start-sampling edge until result_valid falls.
REQ-014 result_valid  output  1  one-cycle completion pulse.
REQ-015 result  output  32  signed dot-product result, held until the next start.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN and DONE: IDLE->RUN on start; RUN->DRAIN after n pops; DRAIN->DONE after 2 cycles; DONE->IDLE after 1 cycle.
REQ-017 Effective count n SHALL be min(len, DEPTH); len=0 SHALL give n=0, skip RUN, and go straight to DRAIN.
REQ-018 On the edge sampling start, the accumulator SHALL be cleared, n and relu_en latched, and the word index set to 0.
REQ-019 fifo_ce SHALL be high for exactly n consecutive cycles, starting the cycle after the start-sampling edge, and SHALL be low in all other states.
REQ-020 Each word read SHALL be registered with weight[word index]; word index increments per pop.
REQ-021 Stage 2 SHALL register the four signed 8x8 products (16-bit each).
REQ-022 Stage 3 SHALL add the sign-extended sum of the four products to the 32-bit accumulator; no overflow is possible (|acc| <= 524288).
REQ-023 result_valid SHALL pulse for one cycle, exactly n+3 edges after the start-sampling edge.
REQ-024 result SHALL update on that same edge: if relu_en is latched and acc<0 then 0, else acc.
REQ-025 start while busy SHALL be ignored.
REQ-026 A weight write SHALL take effect at the clk edge when wgt_we=1 and busy=0; weight writes while busy=1 SHALL be ignored.
REQ-027 Start and wgt_we asserted in the same cycle while idle: both SHALL be accepted, and the run SHALL use the newly written weight.
REQ-028 The block SHALL never assume FIFO occupancy: the integrator guarantees ≥n words are present and that FIFO we is low while busy.

Reset
REQ-029 rst SHALL immediately force state IDLE and clear fifo_ce, busy, result_valid, result, the accumulator, all pipeline registers and all weights to 0, including mid-run.
REQ-030 After rst is released, the first start SHALL behave per REQ-018.

Structure
REQ-031 Package nn_pkg SHALL hold the DEPTH default, the state enum, and the LANES=4 and LANE_W=8 constants.
REQ-032 Sub-module nn_dot4 SHALL compute the four-lane signed dot product for stages 2-3.
REQ-033 The weight memory SHALL be a DEPTH x 32 register array.

Verification
REQ-034 Load all weights 0x01010101; FIFO holds 3 words 0x02020202; start with len=3 -> three fifo_ce cycles; result=24; result_valid pulses 6 edges after start.
REQ-035 Weights 0x000000FF (-1 in lane0), word 0x00000005, len=1: relu_en=0 -> result=0xFFFFFFFB; relu_en=1 -> result=0.
REQ-036 len=0 -> no fifo_ce; result=0; result_valid 3 edges after start.
REQ-037 len=12 -> exactly 8 pops; result_valid 11 edges after start.
REQ-038 Start, wgt_we and a second start asserted mid-run -> ignored; result matches the original weights.
REQ-039 Assert rst during RUN -> fifo_ce and busy low the same cycle; result=0; a subsequent run is correct.
